hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
// - Central stall/flush/halt sequencer for the 5-stage RV32I pipeline.
// - Drives the enable and flush controls of the F/D, D/E, E/M and M/W pipeline registers.
// - Resolves load-use hazards, taken-branch/jump redirects and data-memory wait states.
// - Sequences an orderly halt on ECALL/EBREAK: stop fetch, drain older instrs, assert halted.
// PARAMETERS
// - DRAIN_CYCLES  3   non-stalled cycles from leaving D until the halt instr retires (E,M,W)
// - CNT_W         32  width of each perf counter (used only with HAZARD_PERF_EN)
// PORTS
// - clk          in   1  clock, rising edge
// - reset        in   1  synchronous, active-high
// - rs1_d        in   5  rs1 of instr in D
// - rs2_d        in   5  rs2 of instr in D
// - use_rs1_d    in   1  instr in D reads rs1
// - use_rs2_d    in   1  instr in D reads rs2
// - halt_d       in   1  instr in D is ECALL/EBREAK
// - rd_e         in   5  rd of instr in E
// - memread_e    in   1  instr in E is a load
// - redirect_e   in   1  taken branch/jump resolved in E
// - memreq_m     in   1  instr in M accesses dmem
// - dmem_ready   in   1  dmem completes this cycle
// - stall_f      out  1  hold PC
// - stall_d      out  1  hold F/D (F/D enable = ~halted & ~stall_d)
// - flush_d      out  1  load NOP into F/D
// - stall_e      out  1  hold D/E
// - flush_e      out  1  load bubble into D/E
// - stall_m      out  1  hold E/M
// - flush_w      out  1  load bubble into M/W
// - halted       out  1  pipeline halted; registered, = (state==HALTED)
// BEHAVIOUR
// - Control outputs are combinational from state and inputs. Each is 0 unless a rule below sets it.
// - lu  = memread_e & rd_e!=0 & ((use_rs1_d & rs1_d==rd_e) | (use_rs2_d & rs2_d==rd_e))
// - dw  = memreq_m & ~dmem_ready
// - Priority in RUN, highest first:
//   - 1. dw: stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1.
//   - 2. redirect_e: flush_d = flush_e = 1; no stalls. Overrides lu (the D instr is killed).
//   - 3. lu: stall_f = stall_d = 1; flush_e = 1. Exactly one bubble per hazard.
// - FSM states: RUN, DRAIN, HALTED. Reset -> RUN, drain_cnt = 0, halted = 0.
// - RUN -> DRAIN on halt_d & ~dw & ~redirect_e & ~lu. drain_cnt <= DRAIN_CYCLES-1.
//   - The halt instr advances to E on that edge.
// - DRAIN:
//   - stall_f = 1, flush_d = 1: nothing younger enters.
//   - dw rule still applies; when dw, drain_cnt holds and flush_d = 0.
//   - Otherwise drain_cnt decrements. At drain_cnt==0 and ~dw -> HALTED.
// - HALTED:
//   - halted = 1; stall_f, stall_d, stall_e, stall_m = 1; flush_* = 0.
//   - All inputs are ignored. Only reset exits.
// - reset in any state, including mid-DRAIN, returns to RUN on the next edge. Counters clear.
// - Simultaneous halt_d with redirect_e: redirect wins, no DRAIN entry (halt instr flushed).
// - Simultaneous halt_d with lu: stall first; DRAIN entry happens on a later non-stalled cycle.
// - rd_e==0 never raises lu.
// CONFIGURATION
// - HAZARD_PERF_EN defined: adds outputs lu_cnt, redir_cnt, dw_cnt, each [CNT_W-1:0].
//   - Each increments once per cycle its rule is the active (winning) rule.
//   - Counting applies only in RUN/DRAIN. Each saturates at all-ones and is cleared by reset.
// - HAZARD_PERF_EN undefined: no counters and no extra ports; behaviour otherwise identical.
// TESTING
// - lu: memread_e=1, rd_e=5, rs1_d=5, use_rs1_d=1 for 1 cycle
//   -> stall_f=stall_d=flush_e=1 that cycle only; all 0 next cycle.
// - redirect_e=1 together with the lu condition above
//   -> flush_d=flush_e=1, stall_f=stall_d=0.
// - memreq_m=1, dmem_ready=0 for 3 cycles, then 1
//   -> stall_f/d/e/m=1 and flush_w=1 for exactly 3 cycles; 0 on the 4th.
// - halt_d=1, no hazards
//   -> DRAIN for 3 cycles with stall_f=flush_d=1; halted=1 from cycle 4 onward.
// - halt sequence with dw for 2 cycles during DRAIN
//   -> halted rises 2 cycles later (cycle 6).
// - reset=1 while in DRAIN
//   -> next cycle state RUN, halted=0, all outputs 0.
// - HAZARD_PERF_EN: 2 lu events + 1 redirect
//   -> lu_cnt=2, redir_cnt=1, dw_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/halt sequencer for the 5-stage RV32I pipeline (optional perf counters: HAZARD_PERF_EN)
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       use_rs1_d,
  input  logic       use_rs2_d,
  input  logic       halt_d,
  input  logic [4:0] rd_e,
  input  logic       memread_e,
  input  logic       redirect_e,
  input  logic       memreq_m,
  input  logic       dmem_ready,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       stall_e,
  output logic       flush_e,
  output logic       stall_m,
  output logic       flush_w,
  output logic       halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] redir_cnt,
  output logic [CNT_W-1:0] dw_cnt
`endif
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state;
  logic [CW-1:0] drain_cnt;

  logic rs1_hit;
  logic rs2_hit;
  logic lu;
  logic dw;
  logic halt_go;

  // load-use needs a real destination; x0 is never a dependency
  assign rs1_hit = use_rs1_d && (rs1_d == rd_e);
  assign rs2_hit = use_rs2_d && (rs2_d == rd_e);
  assign lu      = memread_e && (rd_e != 5'd0) && (rs1_hit || rs2_hit);
  assign dw      = memreq_m && !dmem_ready;
  // halt instr may only leave D on a cycle where nothing stalls or kills it
  assign halt_go = halt_d && !dw && !redirect_e && !lu;

  // combinational pipeline-register controls, priority dw > redirect > lu
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    stall_m = 1'b0;
    flush_w = 1'b0;
    case (state)
      RUN: begin
        if (dw) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end else if (redirect_e) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lu) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      DRAIN: begin
        stall_f = 1'b1;
        if (dw) begin
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      HALTED: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // halt sequencer: count down non-stalled drain cycles, then freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= CW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (!dw) begin
            if (drain_cnt == '0) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
        end
        HALTED: begin
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic win_lu;
  logic win_redir;
  logic win_dw;

  // only the winning rule of a cycle counts; HALTED counts nothing
  assign win_dw    = (state == RUN || state == DRAIN) && dw;
  assign win_redir = (state == RUN) && !dw && redirect_e;
  assign win_lu    = (state == RUN) && !dw && !redirect_e && lu;

  // saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_cnt    <= '0;
      redir_cnt <= '0;
      dw_cnt    <= '0;
    end else begin
      if (win_lu && (lu_cnt != '1))
        lu_cnt <= lu_cnt + 1'b1;
      if (win_redir && (redir_cnt != '1))
        redir_cnt <= redir_cnt + 1'b1;
      if (win_dw && (dw_cnt != '1))
        dw_cnt <= dw_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int DRAIN = 3;
  localparam int CW    = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       use_rs1_d, use_rs2_d, halt_d, memread_e, redirect_e, memreq_m, dmem_ready;
  logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w, halted;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] lu_cnt, redir_cnt, dw_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .halt_d(halt_d), .rd_e(rd_e), .memread_e(memread_e), .redirect_e(redirect_e),
    .memreq_m(memreq_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .stall_e(stall_e),
    .flush_e(flush_e), .stall_m(stall_m), .flush_w(flush_w), .halted(halted)
`ifdef HAZARD_PERF_EN
    , .lu_cnt(lu_cnt), .redir_cnt(redir_cnt), .dw_cnt(dw_cnt)
`endif
  );

  // model state: draining flag, completed drain cycles, halted flag, event tallies
  bit m_draining, m_halted;
  int m_done;
  int m_lu, m_redir, m_dw;

  function automatic bit f_lu();
    return memread_e && rd_e != 0 &&
           ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
  endfunction

  function automatic bit f_dw();
    return memreq_m && !dmem_ready;
  endfunction

  // bit order {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w}
  function automatic logic [6:0] model_ctrl();
    if (m_halted)   return 7'b1101010;
    if (f_dw())     return 7'b1101011;
    if (m_draining) return 7'b1010000;
    if (redirect_e) return 7'b0010100;
    if (f_lu())     return 7'b1100100;
    return 7'b0000000;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_draining <= 1'b0; m_halted <= 1'b0; m_done <= 0;
      m_lu <= 0; m_redir <= 0; m_dw <= 0;
    end else if (!m_halted) begin
      if (f_dw()) m_dw <= m_dw + 1;
      if (m_draining) begin
        if (!f_dw()) begin
          m_done <= m_done + 1;
          if (m_done + 1 == DRAIN) begin
            m_halted   <= 1'b1;
            m_draining <= 1'b0;
          end
        end
      end else if (!f_dw()) begin
        if (redirect_e) m_redir <= m_redir + 1;
        else if (f_lu()) m_lu <= m_lu + 1;
        else if (halt_d) begin
          m_draining <= 1'b1;
          m_done     <= 0;
        end
      end
    end
  end

  logic [6:0] got_ctrl;
  assign got_ctrl = {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w};

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (got_ctrl !== model_ctrl()) begin
        errors++;
        $display("FAIL ctrl t=%0t got=%b exp=%b", $time, got_ctrl, model_ctrl());
      end
      checks++;
      if (halted !== m_halted) begin
        errors++;
        $display("FAIL halted t=%0t got=%b exp=%b", $time, halted, m_halted);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (lu_cnt !== CW'(m_lu) || redir_cnt !== CW'(m_redir) || dw_cnt !== CW'(m_dw)) begin
        errors++;
        $display("FAIL counters t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
                 lu_cnt, redir_cnt, dw_cnt, m_lu, m_redir, m_dw);
      end
`endif
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_d = 0; rs2_d = 0; rd_e = 0; use_rs1_d = 0; use_rs2_d = 0; halt_d = 0;
    memread_e = 0; redirect_e = 0; memreq_m = 0; dmem_ready = 0;
  endtask

  task automatic set_lu_rs1();
    memread_e = 1; rd_e = 5; rs1_d = 5; use_rs1_d = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset = 1;
    tick(); tick();
    chk_en = 1;
    reset = 0;
    #2;
    lit("reset_ctrl", 32'(got_ctrl), 32'h0);
    lit("reset_halted", 32'(halted), 32'h0);

    // single load-use hazard
    tick(); set_lu_rs1(); #2;
    lit("lu_ctrl", 32'(got_ctrl), 32'b1100100);
    tick(); clr(); #2;
    lit("lu_after", 32'(got_ctrl), 32'h0);

    // redirect overrides load-use
    tick(); set_lu_rs1(); redirect_e = 1; #2;
    lit("redir_lu_ctrl", 32'(got_ctrl), 32'b0010100);

    // load-use through rs2
    tick(); clr(); memread_e = 1; rd_e = 9; rs2_d = 9; use_rs2_d = 1; rs1_d = 9; #2;
    lit("lu_rs2_ctrl", 32'(got_ctrl), 32'b1100100);

    // rd_e == 0 never hazards
    tick(); clr(); memread_e = 1; rd_e = 0; rs1_d = 0; use_rs1_d = 1; #2;
    lit("lu_x0", 32'(got_ctrl), 32'h0);
`ifdef HAZARD_PERF_EN
    tick(); clr(); #2;
    lit("perf_lu", lu_cnt, 32'd2);
    lit("perf_redir", redir_cnt, 32'd1);
    lit("perf_dw", dw_cnt, 32'd0);
`endif

    // dmem wait for 3 cycles
    for (int c = 0; c < 3; c++) begin
      tick(); clr(); memreq_m = 1; dmem_ready = 0; #2;
      lit("dw_ctrl", 32'(got_ctrl), 32'b1101011);
    end
    tick(); memreq_m = 1; dmem_ready = 1; #2;
    lit("dw_done", 32'(got_ctrl), 32'h0);

    // clean halt
    tick(); clr(); halt_d = 1;
    for (int c = 1; c <= 3; c++) begin
      tick(); clr(); #2;
      lit("drain_ctrl", 32'(got_ctrl), 32'b1010000);
      lit("drain_halted", 32'(halted), 32'h0);
    end
    tick(); #2;
    lit("halted_c4", 32'(halted), 32'h1);
    tick(); set_lu_rs1(); redirect_e = 1; memreq_m = 1; halt_d = 1; #2;
    lit("halted_ignores", 32'(got_ctrl), 32'b1101010);

    // reset out of HALTED
    tick(); clr(); reset = 1;
    tick(); reset = 0; #2;
    lit("rst_from_halt", 32'(halted), 32'h0);

    // halt with 2 dw cycles during DRAIN -> halted at cycle 6
    tick(); halt_d = 1;
    tick(); clr();
    tick(); memreq_m = 1;
    tick();
    tick(); clr();
    tick(); #2;
    lit("halt_dw_c5", 32'(halted), 32'h0);
    tick(); #2;
    lit("halt_dw_c6", 32'(halted), 32'h1);

    tick(); reset = 1;
    tick(); reset = 0;

    // halt together with redirect: no drain
    tick(); halt_d = 1; redirect_e = 1;
    tick(); clr(); #2;
    lit("halt_redir", 32'(got_ctrl), 32'h0);

    // halt together with load-use: stall first, drain next
    tick(); halt_d = 1; set_lu_rs1(); #2;
    lit("halt_lu_stall", 32'(got_ctrl), 32'b1100100);
    tick(); clr(); halt_d = 1;
    tick(); clr(); #2;
    lit("halt_lu_drain", 32'(got_ctrl), 32'b1010000);

    // reset in the middle of DRAIN
    tick(); reset = 1;
    tick(); reset = 0; #2;
    lit("rst_drain_ctrl", 32'(got_ctrl), 32'h0);
    lit("rst_drain_halted", 32'(halted), 32'h0);

    tick(); tick();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
